// File: rtl/pfd.sv
// pfd: clocked tri-state phase-frequency detector.
// Rising edges of the reference (link) and oscillator feedback (vco) are
// synchronized and edge-detected. A three-state FSM then issues up/dn
// correction pulses. Every output is driven straight from a flop; the
// complements add only one inverter.
module pfd #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link,
  input  logic       vco,
  output logic [1:0] setting,
  output logic       up,
  output logic       dn,
  output logic       upb,
  output logic       dnb
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DN   = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] link_sync;
  logic [SYNC_STAGES-1:0] vco_sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   link_dly;
  logic                   vco_dly;
  logic                   link_arm;
  logic                   vco_arm;
  logic                   link_s;
  logic                   vco_s;
  logic                   fill_done;
  logic                   re_link;
  logic                   re_vco;

  state_t state;
  logic   pulse_up;
  logic   pulse_dn;
  logic   pulse_on;
  logic   dir;

  assign link_s    = link_sync[SYNC_STAGES-1];
  assign vco_s     = vco_sync[SYNC_STAGES-1];
  assign fill_done = fill[SYNC_STAGES-1];

  // Input synchronizers, one-cycle delay flops and a fill marker that tracks
  // when the synchronizer output reflects real post-reset samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_sync <= '0;
      vco_sync  <= '0;
      fill      <= '0;
      link_dly  <= 1'b0;
      vco_dly   <= 1'b0;
    end else begin
      link_sync <= {link_sync[SYNC_STAGES-2:0], link};
      vco_sync  <= {vco_sync[SYNC_STAGES-2:0], vco};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      link_dly  <= link_s;
      vco_dly   <= vco_s;
    end
  end

  // An input only becomes eligible for edge detection after a genuine low
  // has been seen following reset. An input that is already high at reset
  // release therefore yields no edge until it falls and rises again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_arm <= 1'b0;
      vco_arm  <= 1'b0;
    end else begin
      link_arm <= link_arm | (fill_done & ~link_s);
      vco_arm  <= vco_arm  | (fill_done & ~vco_s);
    end
  end

  assign re_link = link_s & ~link_dly & link_arm;
  assign re_vco  = vco_s  & ~vco_dly  & vco_arm;

  // Tri-state FSM with registered pulse, activity and direction flags.
  // The direction flag is loaded only when a pulse starts and is held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pulse_up <= 1'b0;
      pulse_dn <= 1'b0;
      pulse_on <= 1'b0;
      dir      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (re_link && !re_vco) begin
            state    <= UP;
            pulse_up <= 1'b1;
            pulse_dn <= 1'b0;
            pulse_on <= 1'b1;
            dir      <= 1'b0;
          end else if (re_vco && !re_link) begin
            state    <= DN;
            pulse_up <= 1'b0;
            pulse_dn <= 1'b1;
            pulse_on <= 1'b1;
            dir      <= 1'b1;
          end else begin
            state    <= IDLE;
            pulse_up <= 1'b0;
            pulse_dn <= 1'b0;
            pulse_on <= 1'b0;
          end
        end
        UP: begin
          if (re_vco) begin
            state    <= IDLE;
            pulse_up <= 1'b0;
            pulse_on <= 1'b0;
          end else begin
            state    <= UP;
          end
        end
        DN: begin
          if (re_link) begin
            state    <= IDLE;
            pulse_dn <= 1'b0;
            pulse_on <= 1'b0;
          end else begin
            state    <= DN;
          end
        end
        default: begin
          state    <= IDLE;
          pulse_up <= 1'b0;
          pulse_dn <= 1'b0;
          pulse_on <= 1'b0;
        end
      endcase
    end
  end

  assign up      = pulse_up;
  assign dn      = pulse_dn;
  assign upb     = ~pulse_up;
  assign dnb     = ~pulse_dn;
  assign setting = {dir, pulse_on};

endmodule

// File: tb/tb_pfd.sv
// Self-checking bench for pfd. Inputs are driven on the falling clock edge and
// sampled by a reference model on the rising edge. The model records the input
// history since reset release, turns 0->1 sample pairs into edges that take
// effect SYNC_STAGES edges later, and tracks pulse direction from those edges.
module tb_pfd;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       link = 1'b0;
  logic       vco = 1'b0;
  logic [1:0] setting;
  logic       up, dn, upb, dnb;

  int n_cmp = 0;
  int n_err = 0;

  bit hl[$];
  bit hv[$];
  int m_pulse = 0;   // 0 none, +1 up pulse, -1 down pulse
  bit m_dir   = 1'b0;

  always #5 clk = ~clk;

  pfd #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .link(link), .vco(vco),
    .setting(setting), .up(up), .dn(dn), .upb(upb), .dnb(dnb)
  );

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {2'b00, setting, up, dn, upb, dnb};
  endfunction

  function automatic logic [7:0] model_vec();
    bit mu, md;
    mu = (m_pulse == 1);
    md = (m_pulse == -1);
    return {2'b00, m_dir, mu | md, mu, md, ~mu, ~md};
  endfunction

  // Edge seen by the FSM at rising edge m: a 0->1 pair in the recorded samples
  // S edges earlier, where the low sample was taken after reset release.
  function automatic bit edge_in(input int m, input bit on_link);
    int n;
    n = m - S;
    if (n < 1) return 1'b0;
    if (on_link) return hl[n] && !hl[n-1];
    return hv[n] && !hv[n-1];
  endfunction

  task automatic cyc(input bit l, input bit v, input string tag);
    int m;
    bit rl, rv;
    @(negedge clk);
    link = l;
    vco  = v;
    @(posedge clk);
    if (!rst) begin
      hl.push_back(l);
      hv.push_back(v);
      m  = hl.size() - 1;
      rl = edge_in(m, 1'b1);
      rv = edge_in(m, 1'b0);
      if (m_pulse == 0) begin
        if (rl && !rv) begin m_pulse = 1;  m_dir = 1'b0; end
        else if (rv && !rl) begin m_pulse = -1; m_dir = 1'b1; end
      end else if (m_pulse == 1) begin
        if (rv) m_pulse = 0;
      end else begin
        if (rl) m_pulse = 0;
      end
    end
    #1;
    check_val(tag, dut_vec(), model_vec());
  endtask

  // Reset asserted right after a falling edge, with the outputs checked before
  // any rising edge occurs; then inputs toggle under reset and settle to l/v.
  task automatic do_reset(input bit l, input bit v);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("rst_async", dut_vec(), 8'b0000_0011);
    hl.delete();
    hv.delete();
    m_pulse = 0;
    m_dir   = 1'b0;
    for (int i = 0; i < 4; i++) cyc(i[0], ~i[0], "rst_hold");
    cyc(l, v, "rst_hold");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int hold_l, hold_v;
    bit rl_v, rv_v;

    // Reset with inputs toggling
    do_reset(1'b0, 1'b0);

    // Link leads by 10 cycles
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, "pre_ll");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, i >= 10, "link_lead");
      if (up === 1'b1) cnt++;
    end
    check_val("ll_width", cnt[7:0], 8'd10);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, "post_ll");

    // Vco leads by 7 cycles
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(i >= 7, 1'b1, "vco_lead");
      if (dn === 1'b1) cnt++;
    end
    check_val("vl_width", cnt[7:0], 8'd7);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, "post_vl");

    // Simultaneous edges give no pulse and keep the direction bit
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, "simul");
      if (setting[0] === 1'b1) cnt++;
    end
    check_val("simul_none", cnt[7:0], 8'd0);
    check_val("simul_dir", {7'd0, setting[1]}, 8'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, "post_simul");

    // Frequency error: link period 20, vco period 40
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      cyc((i % 20) < 10, ((i + 5) % 40) < 20, "freq");
      if (dn === 1'b1) cnt++;
    end
    check_val("freq_no_dn", cnt[7:0], 8'd0);

    // Reset in the middle of an up pulse
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, "pre_mid");
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, "mid_pulse");
    check_val("mid_up", {7'd0, up}, 8'd1);
    do_reset(1'b1, 1'b0);

    // Link high across reset release: only the second rise counts
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, "slow_hi");
      if (up === 1'b1) cnt++;
    end
    check_val("slow_none", cnt[7:0], 8'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, "slow_lo");
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, i >= 4, "slow_rise");
      if (up === 1'b1) cnt++;
    end
    check_val("slow_width", cnt[7:0], 8'd4);

    // Randomized inputs, each level held at least 2 cycles
    rl_v = 1'b0;
    rv_v = 1'b0;
    hold_l = 2;
    hold_v = 3;
    for (int i = 0; i < 2000; i++) begin
      if (hold_l == 0) begin rl_v = ~rl_v; hold_l = $urandom_range(2, 14); end
      if (hold_v == 0) begin rv_v = ~rv_v; hold_v = $urandom_range(2, 14); end
      hold_l--;
      hold_v--;
      cyc(rl_v, rv_v, "random");
      if (i == 1000) do_reset(rl_v, rv_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
